lsu_mem_initiator: RTL and testbench

- CPU-side load/store initiator that drives the byte-addressed data memory port (sw/sb/lw/lbu strobes, combinational read, write on clock edge).
- Accepts one pipeline memory request via valid/ready and returns one response pulse.
- Builds the full RV32 access set (LB/LH/LW/LBU/LHU/SB/SH/SW, aligned or misaligned) from the four primitive memory operations, one primitive per cycle.

---
 rtl/lsu_mem_initiator.sv | 151 +++++++++++++++
 tb/tb_lsu_mem_initiator.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lsu_mem_initiator.sv
// Load/store initiator: turns one RV32 memory request into a sequence of
// primitive word/byte memory operations, one per cycle, then one response pulse.
module lsu_mem_initiator #(
  parameter bit ALLOW_MISALIGNED = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        mem_sw,
  output logic        mem_sb,
  output logic        mem_lw,
  output logic        mem_lbu,
  input  logic [31:0] mem_rdata
);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_e;

  state_e      state_q, state_d;
  logic        we_q, uns_q, word_q, err_q;
  logic [1:0]  size_q;
  logic [1:0]  beat_q;
  logic [1:0]  last_q;
  logic [31:0] addr_q, wdata_q, asm_q;

  logic        accept;
  logic        plan_word, plan_err;
  logic [1:0]  plan_last;
  logic [7:0]  wdata_byte;

  assign accept     = req_valid && (state_q == IDLE);
  assign req_ready  = (state_q == IDLE);
  assign wdata_byte = wdata_q[{beat_q, 3'b000} +: 8];

  // Beat plan decided from the live request; plan_last is the index of the final beat.
  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    plan_word = 1'b0;
    plan_err  = 1'b0;
    plan_last = 2'd0;
    unique case (req_size)
      2'd0: plan_last = 2'd0;
      2'd1: plan_last = 2'd1;
      2'd2: begin
        if (req_addr[1:0] == 2'b00) plan_word = 1'b1;
        else if (ALLOW_MISALIGNED)  plan_last = 2'd3;
        else                        plan_err  = 1'b1;
      end
      default: plan_err = 1'b1;
    endcase
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (accept) state_d = plan_err ? RESP : ACCESS;
      ACCESS:  if (beat_q == last_q) state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      we_q    <= 1'b0;
      uns_q   <= 1'b0;
      word_q  <= 1'b0;
      err_q   <= 1'b0;
      size_q  <= 2'd0;
      beat_q  <= 2'd0;
      last_q  <= 2'd0;
      addr_q  <= 32'd0;
      wdata_q <= 32'd0;
      asm_q   <= 32'd0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        we_q    <= req_we;
        uns_q   <= req_unsigned;
        word_q  <= plan_word;
        err_q   <= plan_err;
        size_q  <= req_size;
        last_q  <= plan_last;
        addr_q  <= req_addr;
        wdata_q <= req_wdata;
        beat_q  <= 2'd0;
        asm_q   <= 32'd0;
      end else if (state_q == ACCESS) begin
        beat_q <= beat_q + 2'd1;
        if (!we_q) begin
          if (word_q) asm_q <= mem_rdata;
          else        asm_q[{beat_q, 3'b000} +: 8] <= mem_rdata[7:0];
        end
      end
    end
  end

  // Memory drive is purely a function of state so an async reset drops strobes at once.
  always_comb begin
    mem_addr  = 32'd0;
    mem_wdata = 32'd0;
    mem_sw    = 1'b0;
    mem_sb    = 1'b0;
    mem_lw    = 1'b0;
    mem_lbu   = 1'b0;
    if (state_q == ACCESS) begin
      mem_addr = addr_q + {30'd0, beat_q};
      if (we_q) begin
        if (word_q) begin
          mem_sw    = 1'b1;
          mem_wdata = wdata_q;
        end else begin
          mem_sb    = 1'b1;
          mem_wdata = {24'd0, wdata_byte};
        end
      end else begin
        if (word_q) mem_lw  = 1'b1;
        else        mem_lbu = 1'b1;
      end
    end
  end

  always_comb begin
    rsp_valid = (state_q == RESP);
    rsp_err   = 1'b0;
    rsp_rdata = 32'd0;
    if (state_q == RESP) begin
      rsp_err = err_q;
      if (!err_q && !we_q) begin
        unique case (size_q)
          2'd0:    rsp_rdata = {{24{~uns_q & asm_q[7]}}, asm_q[7:0]};
          2'd1:    rsp_rdata = {{16{~uns_q & asm_q[15]}}, asm_q[15:0]};
          default: rsp_rdata = asm_q;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_lsu_mem_initiator.sv
// Scoreboard bench for lsu_mem_initiator: byte memory model, expected beats and
// responses queued at stimulus time and compared as the DUT produces them.
module tb_lsu_mem_initiator;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          cyc;
  } rsp_t;

  typedef struct {
    logic [31:0] addr;
    logic [3:0]  strb;   // {sw, sb, lw, lbu}
    logic [31:0] wdata;
    bit          st;
  } beat_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid0 = 1'b0, req_valid1 = 1'b0;
  logic        req_we = 1'b0, req_unsigned = 1'b0;
  logic [1:0]  req_size = 2'd0;
  logic [31:0] req_addr = 32'd0, req_wdata = 32'd0;

  logic        req_ready0, rsp_valid0, rsp_err0;
  logic [31:0] rsp_rdata0, m0_addr, m0_wdata, m0_rdata;
  logic        m0_sw, m0_sb, m0_lw, m0_lbu;
  logic        req_ready1, rsp_valid1, rsp_err1;
  logic [31:0] rsp_rdata1, m1_addr, m1_wdata;
  logic        m1_sw, m1_sb, m1_lw, m1_lbu;

  logic [7:0]  mem_b [4096];
  logic [7:0]  ref_b [4096];
  int          cyc = 0;
  int          n_checks = 0;
  int          n_errors = 0;
  rsp_t        rsp_q[$];
  beat_t       beat_q[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  lsu_mem_initiator #(.ALLOW_MISALIGNED(1'b1)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid0), .req_ready(req_ready0), .req_we(req_we),
    .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
    .req_wdata(req_wdata), .rsp_valid(rsp_valid0), .rsp_rdata(rsp_rdata0),
    .rsp_err(rsp_err0), .mem_addr(m0_addr), .mem_wdata(m0_wdata),
    .mem_sw(m0_sw), .mem_sb(m0_sb), .mem_lw(m0_lw), .mem_lbu(m0_lbu),
    .mem_rdata(m0_rdata)
  );

  lsu_mem_initiator #(.ALLOW_MISALIGNED(1'b0)) dut_strict (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid1), .req_ready(req_ready1), .req_we(req_we),
    .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
    .req_wdata(req_wdata), .rsp_valid(rsp_valid1), .rsp_rdata(rsp_rdata1),
    .rsp_err(rsp_err1), .mem_addr(m1_addr), .mem_wdata(m1_wdata),
    .mem_sw(m1_sw), .mem_sb(m1_sb), .mem_lw(m1_lw), .mem_lbu(m1_lbu),
    .mem_rdata(32'd0)
  );

  // Byte-addressed memory (4 KiB, address wraps on 12 bits).
  always @* begin
    m0_rdata = {mem_b[m0_addr[11:0] + 12'd3], mem_b[m0_addr[11:0] + 12'd2],
                mem_b[m0_addr[11:0] + 12'd1], mem_b[m0_addr[11:0]]};
  end

  always @(posedge clk) begin
    if (m0_sw) begin
      for (int i = 0; i < 4; i++) mem_b[m0_addr[11:0] + 12'(i)] <= m0_wdata[8*i +: 8];
    end
    if (m0_sb) mem_b[m0_addr[11:0]] <= m0_wdata[7:0];
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Response scoreboard.
  always @(negedge clk) begin
    if (rst_n) begin
      if (rsp_valid0) begin
        check("busy_not_ready", 32'(req_ready0), 32'd0);
        if (rsp_q.size() == 0) begin
          check("rsp_unexpected", 32'd1, 32'd0);
        end else begin
          rsp_t e;
          e = rsp_q.pop_front();
          check("rsp_rdata", rsp_rdata0, e.rdata);
          check("rsp_err", 32'(rsp_err0), 32'(e.err));
          check("rsp_cycle", 32'(cyc), 32'(e.cyc));
        end
      end else begin
        check("rsp_idle_zero", rsp_rdata0 | 32'(rsp_err0), 32'd0);
      end
    end
  end

  // Memory beat scoreboard.
  always @(negedge clk) begin
    if (rst_n && (m0_sw | m0_sb | m0_lw | m0_lbu)) begin
      if (beat_q.size() == 0) begin
        check("beat_unexpected", m0_addr, 32'hxxxx_xxxx);
      end else begin
        beat_t b;
        b = beat_q.pop_front();
        check("beat_addr", m0_addr, b.addr);
        check("beat_strobes", {28'd0, m0_sw, m0_sb, m0_lw, m0_lbu}, {28'd0, b.strb});
        if (b.st) check("beat_wdata", m0_wdata, b.wdata);
      end
    end
  end

  task automatic do_req(input logic we, input logic [1:0] size, input logic uns,
                        input logic [31:0] addr, input logic [31:0] wdata);
    int    n;
    bit    word, err;
    logic [31:0] val, a;
    rsp_t  r;
    beat_t b;
    @(negedge clk);
    check("ready_idle", 32'(req_ready0), 32'd1);
    n = 0; word = 0; err = 0;
    case (size)
      2'd0: n = 1;
      2'd1: n = 2;
      2'd2: if (addr[1:0] == 2'b00) begin n = 1; word = 1; end else n = 4;
      default: err = 1;
    endcase
    for (int k = 0; k < n; k++) begin
      val     = wdata >> (8 * k);
      b.addr  = addr + 32'(k);
      b.strb  = word ? (we ? 4'b1000 : 4'b0010) : (we ? 4'b0100 : 4'b0001);
      b.wdata = word ? wdata : {24'd0, val[7:0]};
      b.st    = we;
      beat_q.push_back(b);
    end
    val = 32'd0;
    for (int k = 0; k < (word ? 4 : n); k++) begin
      a = addr + 32'(k);
      if (we) begin
        logic [31:0] sh;
        sh = wdata >> (8 * k);
        ref_b[a[11:0]] = sh[7:0];
      end else begin
        val = val | (32'(ref_b[a[11:0]]) << (8 * k));
      end
    end
    if (!uns && size == 2'd0 && val[7])  val = val | 32'hFFFF_FF00;
    if (!uns && size == 2'd1 && val[15]) val = val | 32'hFFFF_0000;
    r.rdata = (we || err) ? 32'd0 : val;
    r.err   = err;
    r.cyc   = cyc + 1 + n;
    rsp_q.push_back(r);
    req_we = we; req_size = size; req_unsigned = uns; req_addr = addr; req_wdata = wdata;
    req_valid0 = 1'b1;
    @(posedge clk);
    #1;
    req_valid0 = 1'b0;
    req_we = 1'($urandom()); req_size = 2'($urandom()); req_unsigned = 1'($urandom());
    req_addr = $urandom(); req_wdata = $urandom();
    for (int i = 0; i < 20 && rsp_q.size() != 0; i++) @(negedge clk);
    if (rsp_q.size() != 0) begin
      check("rsp_timeout", 32'(rsp_q.size()), 32'd0);
      rsp_q.delete();
    end
    check("beats_left", 32'(beat_q.size()), 32'd0);
    beat_q.delete();
  endtask

  // Strict instance: every request here must be rejected at T+1 with no strobes.
  task automatic err_req_strict(input logic we, input logic [1:0] size, input logic [31:0] addr);
    int t;
    bit seen;
    @(negedge clk);
    t = cyc;
    seen = 0;
    req_we = we; req_size = size; req_unsigned = 1'b0; req_addr = addr;
    req_wdata = 32'hCAFE_F00D;
    req_valid1 = 1'b1;
    @(posedge clk);
    #1;
    req_valid1 = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("strict_strobes", {28'd0, m1_sw, m1_sb, m1_lw, m1_lbu}, 32'd0);
      if (rsp_valid1) begin
        seen = 1;
        check("strict_cycle", 32'(cyc), 32'(t + 1));
        check("strict_err", 32'(rsp_err1), 32'd1);
        check("strict_rdata", rsp_rdata1, 32'd0);
      end
    end
    check("strict_rsp_seen", 32'(seen), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 4096; i++) begin
      mem_b[i] = 8'd0;
      ref_b[i] = 8'd0;
    end
    #12;
    check("rst_ready", 32'(req_ready0), 32'd1);
    check("rst_rsp", {30'd0, rsp_valid0, rsp_err0} | rsp_rdata0, 32'd0);
    check("rst_strobes", {28'd0, m0_sw, m0_sb, m0_lw, m0_lbu}, 32'd0);
    check("rst_mem_bus", m0_addr | m0_wdata, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Aligned word store/load.
    do_req(1'b1, 2'd2, 1'b0, 32'h0000_0100, 32'hDEAD_BEEF);
    do_req(1'b0, 2'd2, 1'b0, 32'h0000_0100, 32'h0);
    // Byte store into a prefilled word, signed and unsigned byte loads.
    do_req(1'b1, 2'd2, 1'b0, 32'h0000_0200, 32'h4433_2211);
    do_req(1'b1, 2'd0, 1'b0, 32'h0000_0203, 32'h1234_5680);
    do_req(1'b0, 2'd0, 1'b0, 32'h0000_0203, 32'h0);
    do_req(1'b0, 2'd0, 1'b1, 32'h0000_0203, 32'h0);
    do_req(1'b0, 2'd2, 1'b0, 32'h0000_0200, 32'h0);
    // Halfword at an odd address.
    do_req(1'b1, 2'd1, 1'b0, 32'h0000_0301, 32'hABCD_8001);
    do_req(1'b0, 2'd1, 1'b0, 32'h0000_0301, 32'h0);
    do_req(1'b0, 2'd1, 1'b1, 32'h0000_0301, 32'h0);
    do_req(1'b0, 2'd0, 1'b1, 32'h0000_0302, 32'h0);
    // Misaligned word split into four byte beats.
    do_req(1'b1, 2'd2, 1'b0, 32'h0000_0402, 32'h1122_3344);
    do_req(1'b0, 2'd2, 1'b0, 32'h0000_0402, 32'h0);
    do_req(1'b0, 2'd1, 1'b0, 32'h0000_0404, 32'h0);
    // Address wrap across 0xFFFFFFFF.
    do_req(1'b1, 2'd0, 1'b0, 32'hFFFF_FFFF, 32'h0000_00A5);
    do_req(1'b1, 2'd0, 1'b0, 32'h0000_0000, 32'h0000_005A);
    do_req(1'b0, 2'd1, 1'b1, 32'hFFFF_FFFF, 32'h0);
    do_req(1'b1, 2'd1, 1'b0, 32'hFFFF_FFFF, 32'h0000_C3B7);
    do_req(1'b0, 2'd1, 1'b0, 32'hFFFF_FFFF, 32'h0);
    // Illegal size: error response, no beats.
    do_req(1'b0, 2'd3, 1'b0, 32'h0000_0100, 32'h0);
    do_req(1'b1, 2'd3, 1'b0, 32'h0000_0100, 32'hFFFF_FFFF);
    do_req(1'b0, 2'd2, 1'b0, 32'h0000_0100, 32'h0);
    // Strict instance rejects misaligned words and illegal size.
    err_req_strict(1'b0, 2'd2, 32'h0000_0402);
    err_req_strict(1'b1, 2'd2, 32'h0000_0401);
    err_req_strict(1'b0, 2'd3, 32'h0000_0100);

    // Reset during beat 2 of a four-beat misaligned store.
    @(negedge clk);
    begin
      beat_t b;
      b.strb = 4'b0100; b.st = 1'b1;
      b.addr = 32'h0000_0501; b.wdata = 32'h0000_00DD; beat_q.push_back(b);
      b.addr = 32'h0000_0502; b.wdata = 32'h0000_00CC; beat_q.push_back(b);
    end
    req_we = 1'b1; req_size = 2'd2; req_unsigned = 1'b0;
    req_addr = 32'h0000_0501; req_wdata = 32'hAABB_CCDD;
    req_valid0 = 1'b1;
    @(posedge clk);
    #1 req_valid0 = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("midrst_strobes", {28'd0, m0_sw, m0_sb, m0_lw, m0_lbu}, 32'd0);
    check("midrst_ready", 32'(req_ready0), 32'd1);
    check("midrst_beats_seen", 32'(beat_q.size()), 32'd0);
    beat_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    check("postrst_ready", 32'(req_ready0), 32'd1);
    check("postrst_byte0", 32'(mem_b[12'h501]), 32'h0000_00DD);
    check("postrst_byte1", 32'(mem_b[12'h502]), 32'h0000_00CC);
    check("postrst_byte2", 32'(mem_b[12'h503]), 32'h0000_0000);
    check("postrst_byte3", 32'(mem_b[12'h504]), 32'h0000_0000);
    ref_b[12'h501] = 8'hDD;
    ref_b[12'h502] = 8'hCC;
    do_req(1'b0, 2'd2, 1'b0, 32'h0000_0500, 32'h0);
    check("word200_byte0", 32'(mem_b[12'h200]), 32'h0000_0011);
    check("word200_byte2", 32'(mem_b[12'h202]), 32'h0000_0033);

    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
